prog_loader: RTL and testbench

Instruction-memory loader for the Pebble processor: the write-side counterpart of the core's fetch path. Accepts a byte stream over a valid/ready handshake, packs byte pairs into 9-bit machine words, writes them sequentially into instruction memory while holding the core in reset, then releases the core, pulses `core_start`, and waits for `core_done`. It sits beside `TopLevel`, driving the instruction-memory write port and the core's `reset`/`start`.

---
 rtl/pebble_pkg.sv | 20 ++
 rtl/prog_loader_if.sv | 23 ++
 rtl/prog_loader.sv | 117 +++++++++++
 tb/tb_prog_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pebble_pkg.sv
// Shared constants and loader state encoding for the Pebble core and its
// instruction-memory loader.
package pebble_pkg;

  localparam int IM_DEPTH = 1024;
  localparam int ADDR_W   = 10;
  localparam int INSTR_W  = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    INS_LO = 3'd3,
    INS_HI = 3'd4,
    START  = 3'd5,
    RUN    = 3'd6,
    ERR    = 3'd7
  } loader_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface prog_loader_if;
  import pebble_pkg::*;

  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               im_we;
  logic [ADDR_W-1:0]  im_addr;
  logic [INSTR_W-1:0] im_wdata;

  // master: the loader; slave: the stream source plus instruction memory
  modport master (
    input  rx_data, rx_valid,
    output rx_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, im_we, im_addr, im_wdata
  );

endinterface

// File: rtl/prog_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding the
// core in reset, then starts the core and waits for it to finish.
//
// state  | meaning
// IDLE   | waiting for load_req, core held in reset
// LEN_LO | receiving program length, low byte
// LEN_HI | receiving program length, high byte (bits [1:0] used)
// INS_LO | receiving instruction bits [7:0]
// INS_HI | receiving instruction bit 8, issuing the write
// START  | core released, start pulse
// RUN    | core running, waiting for core_done
// ERR    | malformed stream, core held in reset, load_err set
module prog_loader
  import pebble_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load_req,
  input  logic          core_done,
  output logic          core_reset,
  output logic          core_start,
  output logic          busy,
  output logic          load_err,
  prog_loader_if.master bus
);

  localparam logic [ADDR_W:0] DEPTH   = (ADDR_W+1)'(IM_DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  loader_state_t     state;
  logic [7:0]        hold;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W:0]   len_rx;
  logic              xfer;
  logic              len_ok;

  assign xfer    = bus.rx_valid && bus.rx_ready;
  assign cnt_inc = word_cnt + CNT_ONE;
  assign len_rx  = {1'b0, bus.rx_data[1:0], hold};
  assign len_ok  = (bus.rx_data[7:2] == 6'd0) && (len_rx != '0) && (len_rx <= DEPTH);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      hold         <= '0;
      word_cnt     <= '0;
      len          <= '0;
      load_err     <= 1'b0;
      bus.im_we    <= 1'b0;
      bus.im_addr  <= '0;
      bus.im_wdata <= '0;
    end else begin
      bus.im_we <= 1'b0;
      case (state)
        IDLE, ERR: begin
          if (load_req) begin
            state    <= LEN_LO;
            load_err <= 1'b0;
            word_cnt <= '0;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            hold  <= bus.rx_data;
            state <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            if (len_ok) begin
              len   <= len_rx;
              state <= INS_LO;
            end else begin
              load_err <= 1'b1;
              state    <= ERR;
            end
          end
        end
        INS_LO: begin
          if (xfer) begin
            hold  <= bus.rx_data;
            state <= INS_HI;
          end
        end
        INS_HI: begin
          if (xfer) begin
            if (bus.rx_data[7:1] != 7'd0) begin
              load_err <= 1'b1;
              state    <= ERR;
            end else begin
              bus.im_we    <= 1'b1;
              bus.im_addr  <= word_cnt[ADDR_W-1:0];
              bus.im_wdata <= {bus.rx_data[0], hold};
              word_cnt     <= cnt_inc;
              state        <= (cnt_inc == len) ? START : INS_LO;
            end
          end
        end
        START: state <= RUN;
        RUN: begin
          if (core_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // All handshake and core-control outputs decode straight from the state register.
  assign bus.rx_ready = (state == LEN_LO) || (state == LEN_HI) ||
                        (state == INS_LO) || (state == INS_HI);
  assign core_reset   = !((state == START) || (state == RUN));
  assign core_start   = (state == START);
  assign busy         = !((state == IDLE) || (state == ERR));

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of complete streams plus hand-written
// reset, done-on-entry and ignored-load_req sequences.
module tb_prog_loader;
  import pebble_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic load_req;
  logic core_done;
  logic core_reset;
  logic core_start;
  logic busy;
  logic load_err;

  prog_loader_if bus ();

  prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load_req   (load_req),
    .core_done  (core_done),
    .core_reset (core_reset),
    .core_start (core_start),
    .busy       (busy),
    .load_err   (load_err),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [ADDR_W-1:0]  a;
    logic [INSTR_W-1:0] d;
  } wr_t;

  wr_t wq[$];

  always @(negedge clk) begin
    if (bus.im_we === 1'b1) wq.push_back('{bus.im_addr, bus.im_wdata});
  end

  typedef struct {
    string      name;
    logic [7:0] bytes [8];
    int         nb;
    bit         gap;
    bit         exp_err;
    int         nw;
    logic [8:0] wd [3];
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      bus.rx_valid = 1'b0;
      tick();
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.rx_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL rx_ready_timeout: got %0b expected 1", bus.rx_ready);
    end
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic chk_writes(input string name, input int nw, input logic [8:0] wd [3]);
    chk({name, "_wr_count"}, 32'(wq.size()), 32'(nw));
    for (int i = 0; i < nw; i++) begin
      if (i < wq.size()) begin
        chk({name, "_wr_addr"}, 32'(wq[i].a), 32'(i));
        chk({name, "_wr_data"}, 32'(wq[i].d), 32'(wd[i]));
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int t0;
    wq.delete();
    load_req = 1'b1;
    t0 = cyc;
    tick();
    load_req = 1'b0;
    chk({v.name, "_err_cleared"}, 32'(load_err), 32'd0);
    chk({v.name, "_busy_load"}, 32'(busy), 32'd1);
    for (int b = 0; b < v.nb; b++) push_byte(v.bytes[b], v.gap);
    if (v.exp_err) begin
      chk({v.name, "_load_err"}, 32'(load_err), 32'd1);
      chk({v.name, "_err_core_reset"}, 32'(core_reset), 32'd1);
      chk({v.name, "_err_busy"}, 32'(busy), 32'd0);
      chk({v.name, "_err_ready"}, 32'(bus.rx_ready), 32'd0);
      tick();
      chk({v.name, "_err_sticky"}, 32'(load_err), 32'd1);
    end else begin
      chk({v.name, "_core_start"}, 32'(core_start), 32'd1);
      chk({v.name, "_core_reset_low"}, 32'(core_reset), 32'd0);
      chk({v.name, "_last_we"}, 32'(bus.im_we), 32'd1);
      if (!v.gap) chk({v.name, "_latency"}, 32'(cyc - t0), 32'(2 * v.nw + 3));
      tick();
      chk({v.name, "_run_start"}, 32'(core_start), 32'd0);
      chk({v.name, "_run_reset"}, 32'(core_reset), 32'd0);
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      chk({v.name, "_done_busy"}, 32'(busy), 32'd0);
      chk({v.name, "_done_reset"}, 32'(core_reset), 32'd1);
    end
    chk_writes(v.name, v.nw, v.wd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"n3",      '{8'h03, 8'h00, 8'h12, 8'h01, 8'h34, 8'h00, 8'hFF, 8'h01}, 8, 1'b0, 1'b0, 3, '{9'h112, 9'h034, 9'h1FF}};
    vecs[1] = '{"n3_gaps", '{8'h03, 8'h00, 8'h12, 8'h01, 8'h34, 8'h00, 8'hFF, 8'h01}, 8, 1'b1, 1'b0, 3, '{9'h112, 9'h034, 9'h1FF}};
    vecs[2] = '{"len0",    '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 1'b0, 1'b1, 0, '{9'h0, 9'h0, 9'h0}};
    vecs[3] = '{"len1025", '{8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 1'b0, 1'b1, 0, '{9'h0, 9'h0, 9'h0}};
    vecs[4] = '{"bad_hi",  '{8'h01, 8'h00, 8'h12, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 1'b0, 1'b1, 0, '{9'h0, 9'h0, 9'h0}};
    vecs[5] = '{"reload",  '{8'h01, 8'h00, 8'hAB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 1'b0, 1'b0, 1, '{9'h0AB, 9'h0, 9'h0}};
    vecs[6] = '{"n2",      '{8'h02, 8'h00, 8'h00, 8'h00, 8'h55, 8'h01, 8'h00, 8'h00}, 6, 1'b1, 1'b0, 2, '{9'h000, 9'h155, 9'h0}};

    reset        = 1'b0;
    load_req     = 1'b0;
    core_done    = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    tick();
    tick();
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_im_we", 32'(bus.im_we), 32'd0);
    chk("rst_im_addr", 32'(bus.im_addr), 32'd0);
    chk("rst_im_wdata", 32'(bus.im_wdata), 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset mid-load after word 1 has been written.
    wq.delete();
    pulse_load();
    push_byte(8'h03, 1'b0);
    push_byte(8'h00, 1'b0);
    push_byte(8'h12, 1'b0);
    push_byte(8'h01, 1'b0);
    chk("midrst_we_before", 32'(bus.im_we), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_core_reset", 32'(core_reset), 32'd1);
    chk("midrst_im_we", 32'(bus.im_we), 32'd0);
    chk("midrst_rx_ready", 32'(bus.rx_ready), 32'd0);
    tick();
    chk("midrst_idle_hold", 32'(busy), 32'd0);

    // Full load with core_done already high on entry to RUN.
    wq.delete();
    core_done = 1'b1;
    pulse_load();
    for (int b = 0; b < 8; b++) push_byte(vecs[0].bytes[b], 1'b0);
    chk("done_hi_start", 32'(core_start), 32'd1);
    tick();
    chk("done_hi_run_reset", 32'(core_reset), 32'd0);
    tick();
    chk("done_hi_idle_reset", 32'(core_reset), 32'd1);
    chk("done_hi_idle_busy", 32'(busy), 32'd0);
    core_done = 1'b0;
    chk_writes("done_hi", 3, vecs[0].wd);

    // load_req while in INS_LO must be ignored.
    wq.delete();
    pulse_load();
    push_byte(8'h01, 1'b0);
    push_byte(8'h00, 1'b0);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk("ign_req_ready", 32'(bus.rx_ready), 32'd1);
    push_byte(8'hAB, 1'b0);
    push_byte(8'h01, 1'b0);
    chk("ign_req_start", 32'(core_start), 32'd1);
    tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    chk("ign_req_wr_count", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) chk("ign_req_wr_data", 32'(wq[0].d), 32'h1AB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
